// File: rtl/pri_enc_pkg.sv
// Shared definitions for the registered priority encoder.
package pri_enc_pkg;

   // Request count used when the instantiating design does not choose one.
   localparam int unsigned PRI_ENC_DEF_N = 4;

endpackage : pri_enc_pkg

// File: rtl/pri_enc_core.sv
// Combinational priority reduction: index of the highest set request bit.
// A scan from bit 0 upward lets each higher set bit override the index found
// so far, so the structure scales with N without a per-width lookup table.
module pri_enc_core #(
   parameter  int unsigned N = 4,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] Y,
   output logic [W-1:0] idx,
   output logic         any
);

   // Highest-numbered set bit wins; an all-zero vector leaves idx at 0.
   always_comb begin
      idx = '0;
      any = |Y;
      for (int unsigned i = 0; i < N; i++) begin
         if (Y[i]) begin
            idx = W'(i);
         end
      end
   end

endmodule : pri_enc_core

// File: rtl/pri_enc.sv
// Registered N-input priority encoder. A carries the index of the highest
// asserted request and V flags that at least one request was present; V is
// the only way to tell "no request" from "request 0". Loads every cycle.
module pri_enc
   import pri_enc_pkg::*;
#(
   parameter  int unsigned N = PRI_ENC_DEF_N,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] Y,
   output logic [W-1:0] A,
   output logic         V
);

   logic [W-1:0] idx;
   logic         any;

   pri_enc_core #(
      .N (N)
   ) u_core (
      .Y   (Y),
      .idx (idx),
      .any (any)
   );

   // Output register: one-cycle latency, cleared at once by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         A <= '0;
         V <= 1'b0;
      end else begin
         A <= idx;
         V <= any;
      end
   end

endmodule : pri_enc

// File: tb/tb_pri_enc.sv
// Self-checking bench for pri_enc: directed scenarios plus random traffic,
// checked against a log2-style reference model. Runs a 4-input and an
// 8-input instance side by side.
module tb_pri_enc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] y4  = '0;
   logic [1:0] a4;
   logic       v4;
   logic [7:0] y8  = '0;
   logic [2:0] a8;
   logic       v8;

   int errors = 0;
   int checks = 0;

   pri_enc #(.N(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .Y   (y4),
      .A   (a4),
      .V   (v4)
   );

   pri_enc #(.N(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .Y   (y8),
      .A   (a8),
      .V   (v8)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   // Reference: floor(log2(y)) by repeated halving; 0 when y is 0.
   function automatic int ref_idx(input logic [63:0] y);
      int n;
      logic [63:0] v;
      n = 0;
      v = y;
      while (v > 64'd1) begin
         v = v >> 1;
         n++;
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check both outputs of the 4-input instance against the model.
   task automatic check4(input string tag, input logic [3:0] y);
      check({tag, ".A"}, {6'd0, a4}, 8'(ref_idx({60'd0, y})));
      check({tag, ".V"}, {7'd0, v4}, {7'd0, (y != 4'd0)});
   endtask

   task automatic check8(input string tag, input logic [7:0] y);
      check({tag, ".A8"}, {5'd0, a8}, 8'(ref_idx({56'd0, y})));
      check({tag, ".V8"}, {7'd0, v8}, {7'd0, (y != 8'd0)});
   endtask

   // Drive on the falling edge, sample 1 unit after the next rising edge.
   task automatic step(input logic [3:0] ya, input logic [7:0] yb);
      @(negedge clk);
      y4 = ya;
      y8 = yb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] r4;
      logic [7:0] r8;
      logic [1:0] sweep_exp [16];
      sweep_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                    2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

      // 1. Reset holds outputs at zero despite all requests high.
      rst = 1'b1;
      y4  = 4'b1111;
      y8  = 8'hff;
      repeat (3) @(posedge clk);
      #1;
      check("reset.A", {6'd0, a4}, 8'd0);
      check("reset.V", {7'd0, v4}, 8'd0);
      check("reset.A8", {5'd0, a8}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset.A", {6'd0, a4}, 8'd3);
      check("post_reset.V", {7'd0, v4}, 8'd1);

      // 2. Exhaustive sweep against the fixed table.
      for (int i = 0; i < 16; i++) begin
         step(4'(i), 8'd0);
         check($sformatf("sweep%0d.A", i), {6'd0, a4}, {6'd0, sweep_exp[i]});
         check($sformatf("sweep%0d.V", i), {7'd0, v4}, {7'd0, (i != 0)});
      end

      // 3. Latency: consecutive inputs produce results one cycle later each.
      step(4'b0001, 8'd0);
      check("lat0.A", {6'd0, a4}, 8'd0);
      step(4'b1000, 8'd0);
      check("lat1.A", {6'd0, a4}, 8'd3);

      // 4. No request versus request 0.
      step(4'b0000, 8'd0);
      check("zero.A", {6'd0, a4}, 8'd0);
      check("zero.V", {7'd0, v4}, 8'd0);
      step(4'b0001, 8'd0);
      check("req0.A", {6'd0, a4}, 8'd0);
      check("req0.V", {7'd0, v4}, 8'd1);

      // 5. Async reset between edges clears outputs before the next edge.
      step(4'b1111, 8'h80);
      check("pre_rst.A", {6'd0, a4}, 8'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async.A", {6'd0, a4}, 8'd0);
      check("async.V", {7'd0, v4}, 8'd0);
      check("async.A8", {5'd0, a8}, 8'd0);
      check("async.V8", {7'd0, v8}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      y4  = 4'b0100;
      @(posedge clk);
      #1;
      check("resume.A", {6'd0, a4}, 8'd2);
      check("resume.V", {7'd0, v4}, 8'd1);

      // 6. Wider instance.
      step(4'd0, 8'b0010_0110);
      check("n8a.A8", {5'd0, a8}, 8'd5);
      check("n8a.V8", {7'd0, v8}, 8'd1);
      step(4'd0, 8'h80);
      check("n8b.A8", {5'd0, a8}, 8'd7);
      step(4'd0, 8'h00);
      check("n8c.V8", {7'd0, v8}, 8'd0);

      // Random traffic on both instances against the model.
      for (int i = 0; i < 300; i++) begin
         r4 = 4'($urandom_range(0, 15));
         r8 = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) r8 = 8'd1 << $urandom_range(0, 7);
         step(r4, r8);
         check4($sformatf("rnd%0d", i), r4);
         check8($sformatf("rnd%0d", i), r8);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule : tb_pri_enc
